fft_output_buffer: RTL and testbench
====================================

FFT_OUTPUT_BUFFER -- requirements
Module: fft_output_buffer

Interface
REQ-001 SHALL have parameter W, default 16: signed width of each FFT real/imag component.
REQ-002 SHALL have parameter NSamples, default 1024: bins per frame, power of two.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port fft_output_valid  input  1  bin present this cycle; no backpressure toward the FFT.
REQ-006 SHALL have port fft_output_sop  input  1  first bin of a frame, qualified by fft_output_valid.
REQ-007 SHALL have port fft_output_real  input  W  signed real part.
REQ-008 SHALL have port fft_output_imag  input  W  signed imaginary part.
REQ-009 SHALL have port out_valid  output  1  out_data/out_index/out_last valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts when high with out_valid.
REQ-011 SHALL have port out_data  output  2W  bin payload.
REQ-012 SHALL have port out_index  output  $clog2(NSamples)  bin number 0..NSamples-1.
REQ-013 SHALL have port out_last  output  1  high with bin NSamples-1.
REQ-014 SHALL have port overflow  output  1  one-cycle pulse per dropped frame.

Function
REQ-015 SHALL store frames in two ping-pong banks of NSamples entries, each with a full flag.
REQ-016 Write side SHALL have states W_IDLE (discard input) and W_FILL; W_IDLE->W_FILL on valid&sop with a free bank, bin stored at index 0.
REQ-017 In W_FILL each valid bin SHALL be stored at the next index; bin NSamples-1 SHALL set that bank full and return to W_IDLE.
REQ-018 valid&sop while in W_FILL SHALL restart the current bank at index 0; partial frame discarded, no overflow pulse.
REQ-019 valid&sop with no free bank SHALL drop the whole frame, pulse overflow next cycle, remain in W_IDLE until next sop.
REQ-020 Read side SHALL have states R_IDLE and R_DRAIN; drain banks in fill order, index 0 to NSamples-1.
REQ-021 First out_valid of a frame SHALL assert exactly 2 cycles after the cycle its final bin is written, if the read side is idle.
REQ-022 Outputs SHALL hold stable while out_valid&!out_ready; a transfer occurs only on out_valid&out_ready.
REQ-023 With out_ready held high, one bin SHALL transfer per cycle within a frame; at most 2 idle cycles between back-to-back frames.
REQ-024 Transfer of out_last SHALL clear that bank's full flag; the bank SHALL be free to a sop in the following cycle, not the same cycle.
REQ-025 Without the config macro, out_data SHALL be {real, imag}, real in the upper W bits.

Reset
REQ-026 reset SHALL clear both full flags, force W_IDLE/R_IDLE, zero write/read indices, next write bank 0.
REQ-027 After reset: out_valid=0, out_last=0, overflow=0, out_data=0, out_index=0; reset mid-frame SHALL discard all stored and in-flight bins.

Configuration
REQ-028 Macro FFT_OUT_MAG_EN: when defined, out_data SHALL be unsigned real^2+imag^2 in 2W bits (no saturation needed), computed before storage with one extra pipeline register; REQ-021 latency becomes 3 cycles.
REQ-029 When FFT_OUT_MAG_EN is undefined, no multipliers SHALL be instantiated and REQ-025 applies.

Verification
REQ-030 NSamples=8, one frame real=i, imag=-i, out_ready=1 -> 8 transfers, out_data={i,-i}, out_last at index 7, first out_valid 2 cycles after last input.
REQ-031 Three back-to-back frames with out_ready=0 -> frames 1,2 stored, frame 3 dropped, one overflow pulse; releasing out_ready drains frames 1 then 2 intact.
REQ-032 out_ready toggled 1010... during drain -> no bin lost or duplicated, outputs stable while stalled.
REQ-033 sop at index 5 of a frame -> earlier 5 bins discarded, emitted frame is the restarted one.
REQ-034 reset asserted mid-drain at index 3 -> out_valid=0 next cycle, no further output until a new full frame.
REQ-035 FFT_OUT_MAG_EN defined, real=3, imag=-4 -> out_data=25; real=imag=-2^(W-1) -> out_data=2^(2W-1).

Source files
------------

// File: rtl/fft_output_buffer.sv
// Ping-pong frame buffer between an FFT core and a valid/ready consumer.
// Define FFT_OUT_MAG_EN to store real^2+imag^2 instead of {real, imag} (adds one pipeline stage).
module fft_output_buffer #(
  parameter int W        = 16,
  parameter int NSamples = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fft_output_valid,
  input  logic                        fft_output_sop,
  input  logic [W-1:0]                fft_output_real,
  input  logic [W-1:0]                fft_output_imag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*W-1:0]              out_data,
  output logic [$clog2(NSamples)-1:0] out_index,
  output logic                        out_last,
  output logic                        overflow,
  output logic                        dbg_wr_fill,
  output logic                        dbg_rd_drain
);
  // Handshake: a bin moves downstream only on a cycle where out_valid && out_ready;
  // while out_valid && !out_ready, out_data/out_index/out_last hold their values.
  localparam int AW = $clog2(NSamples);
  localparam logic [AW-1:0] LAST_IDX = AW'(NSamples - 1);

  logic           s_valid;
  logic           s_sop;
  logic [2*W-1:0] s_data;

`ifdef FFT_OUT_MAG_EN
  logic signed [W-1:0]   re_s;
  logic signed [W-1:0]   im_s;
  logic signed [2*W-1:0] re_sq;
  logic signed [2*W-1:0] im_sq;

  assign re_s  = fft_output_real;
  assign im_s  = fft_output_imag;
  assign re_sq = re_s * re_s;
  assign im_sq = im_s * im_s;

  // Sum of two squares peaks at 2^(2W-1), so the unsigned 2W-bit result never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_valid <= 1'b0;
      s_sop   <= 1'b0;
      s_data  <= '0;
    end else begin
      s_valid <= fft_output_valid;
      s_sop   <= fft_output_sop;
      s_data  <= $unsigned(re_sq) + $unsigned(im_sq);
    end
  end
`else
  assign s_valid = fft_output_valid;
  assign s_sop   = fft_output_sop;
  assign s_data  = {fft_output_real, fft_output_imag};
`endif

  typedef enum logic {W_IDLE, W_FILL} w_state_t;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_t;

  w_state_t       w_state, w_next;
  r_state_t       r_state, r_next;
  logic           wr_bank, rd_bank;
  logic [AW-1:0]  wr_idx, rd_idx, wr_addr;
  logic [1:0]     full;
  logic           wr_en, set_full, drop;
  logic           load, done;
  logic [2*W-1:0] mem [2*NSamples];

  assign dbg_wr_fill  = (w_state == W_FILL);
  assign dbg_rd_drain = (r_state == R_DRAIN);

  always_comb begin
    w_next   = w_state;
    wr_en    = 1'b0;
    wr_addr  = wr_idx;
    set_full = 1'b0;
    drop     = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (s_valid && s_sop) begin
          if (!full[wr_bank]) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            w_next  = W_FILL;
          end else begin
            drop = 1'b1;
          end
        end
      end
      W_FILL: begin
        if (s_valid) begin
          wr_en = 1'b1;
          if (s_sop) begin
            wr_addr = '0;
          end else if (wr_idx == LAST_IDX) begin
            set_full = 1'b1;
            w_next   = W_IDLE;
          end
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    load   = 1'b0;
    done   = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (full[rd_bank]) begin
          load   = 1'b1;
          r_next = R_DRAIN;
        end
      end
      R_DRAIN: begin
        if (out_ready) begin
          if (out_last) begin
            done   = 1'b1;
            r_next = R_IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= s_data;
  end

  // Full flags are set by the writer and cleared by the reader; the two never target the same bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      full      <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      w_state  <= w_next;
      r_state  <= r_next;
      overflow <= drop;
      if (wr_en) wr_idx <= wr_addr + 1'b1;
      if (set_full) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end
      if (load) begin
        out_data  <= mem[{rd_bank, rd_idx}];
        out_index <= rd_idx;
        out_last  <= (rd_idx == LAST_IDX);
        out_valid <= 1'b1;
        rd_idx    <= rd_idx + 1'b1;
      end
      if (done) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
        out_valid     <= 1'b0;
        out_last      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fft_output_buffer.sv
// Directed bench for fft_output_buffer (NSamples=8); expected bins come from a scoreboard queue.
module tb_fft_output_buffer;
  localparam int W  = 16;
  localparam int NS = 8;
  localparam int AW = 3;
  localparam int EW = 2*W + AW + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          fft_output_valid, fft_output_sop;
  logic [W-1:0]  fft_output_real, fft_output_imag;
  logic          out_valid, out_ready, out_last, overflow;
  logic [2*W-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          dbg_wr_fill, dbg_rd_drain;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] head;
  int n_vec = 0;
  int n_err = 0;
  int ovf_cnt = 0;

  fft_output_buffer #(.W(W), .NSamples(NS)) dut (
    .clk(clk), .reset(reset),
    .fft_output_valid(fft_output_valid), .fft_output_sop(fft_output_sop),
    .fft_output_real(fft_output_real), .fft_output_imag(fft_output_imag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .overflow(overflow),
    .dbg_wr_fill(dbg_wr_fill), .dbg_rd_drain(dbg_rd_drain)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [2*W-1:0] model_word(input int re, input int im);
`ifdef FFT_OUT_MAG_EN
    longint a = re;
    longint b = im;
    return (2*W)'(a*a + b*b);
`else
    logic [W-1:0] r = W'(re);
    logic [W-1:0] i = W'(im);
    return {r, i};
`endif
  endfunction

  // Scoreboard: every valid output is compared with the queue head, stalled or not.
  always @(negedge clk) begin
    if (overflow === 1'b1) ovf_cnt++;
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", out_valid, 0);
      end else begin
        head = exp_q[0];
        check("data", out_data, head[2*W-1:0]);
        check("index", out_index, head[2*W +: AW]);
        check("last", out_last, head[EW-1]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_bin(input bit sop, input int re, input int im);
    fft_output_valid = 1'b1;
    fft_output_sop   = sop;
    fft_output_real  = W'(re);
    fft_output_imag  = W'(im);
    @(posedge clk); #1;
    fft_output_valid = 1'b0;
    fft_output_sop   = 1'b0;
  endtask

  task automatic send_frame(input int rb, input int ib, input bit push);
    for (int i = 0; i < NS; i++) begin
      if (push) exp_q.push_back({(i == NS-1), AW'(i), model_word(rb + i, ib - i)});
      drive_bin(i == 0, rb + i, ib - i);
    end
  endtask

  task automatic wait_drain(input int budget, input bit toggle, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < budget) begin
      if (toggle) out_ready = ~out_ready;
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    int ovf_before;
    bit found;
    reset = 1'b1;
    out_ready = 1'b0;
    fft_output_valid = 1'b0;
    fft_output_sop = 1'b0;
    fft_output_real = '0;
    fft_output_imag = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_ovf", overflow, 0);
    check("rst_data", out_data, 0);
    check("rst_index", out_index, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single frame real=i, imag=-i with latency check.
    out_ready = 1'b1;
    send_frame(0, 0, 1);
    check("lat_early", out_valid, 0);
`ifdef FFT_OUT_MAG_EN
    @(posedge clk); #1;
    check("lat_mag_early", out_valid, 0);
`endif
    @(posedge clk); #1;
    check("lat_first", out_valid, 1);
    wait_drain(50, 0, cyc);
    check("t1_drained", exp_q.size(), 0);

    // Three back-to-back frames while stalled: third one dropped.
    out_ready = 1'b0;
    ovf_before = ovf_cnt;
    send_frame(16, 40, 1);
    send_frame(32, 80, 1);
    send_frame(48, 120, 0);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_pulses", ovf_cnt - ovf_before, 1);
    check("stalled_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_drain(60, 0, cyc);
    check("t2_drained", exp_q.size(), 0);
    check("t2_gap_ok", (cyc <= 2*NS + 3), 1);

    // Drain with out_ready toggling 1010...
    out_ready = 1'b0;
    send_frame(5, -3, 1);
    wait_drain(100, 1, cyc);
    check("t3_drained", exp_q.size(), 0);
    out_ready = 1'b1;

    // Reset in the middle of a drain.
    send_frame(7, 7, 1);
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      if (out_valid === 1'b1 && out_index == 3'd3) found = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("mid_drain_found", found, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    reset = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_last", out_last, 0);
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_quiet", out_valid, 0);

    // Restart: sop after 5 bins discards them.
    ovf_before = ovf_cnt;
    for (int i = 0; i < 5; i++) drive_bin(i == 0, 200 + i, 300 + i);
    send_frame(9, 1, 1);
    wait_drain(50, 0, cyc);
    check("t4_drained", exp_q.size(), 0);
    check("restart_no_ovf", ovf_cnt - ovf_before, 0);

    // Corner values with hand-computed words.
    for (int i = 0; i < NS; i++) begin
`ifdef FFT_OUT_MAG_EN
      exp_q.push_back({(i == NS-1), AW'(i), (i == 0) ? 32'd25 : 32'h8000_0000});
`else
      exp_q.push_back({(i == NS-1), AW'(i), (i == 0) ? 32'h0003_FFFC : 32'h8000_8000});
`endif
      if (i == 0) drive_bin(1'b1, 3, -4);
      else drive_bin(1'b0, -32768, -32768);
    end
    wait_drain(50, 0, cyc);
    check("t6_drained", exp_q.size(), 0);

    repeat (5) @(posedge clk);
    #1;
    check("final_idle", out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
